pu_io_rd_initiator: RTL and testbench
=====================================

// Module: pu_io_rd_initiator
// PURPOSE
//  Per-PU initiator for the io_req/io_cmd -> io_ack/io_ack_data read protocol served by
//  the shared PU lookup memories (e.g. switch-info BRAM). Accepts one read from the PU
//  core, issues a one-cycle io_req with a held io_cmd, waits for the matching io_ack and
//  returns data to the core. Strictly one outstanding request, matching the responder's
//  1-entry per-PU input FIFO. Adds a timeout watchdog and sticky error reporting.
// PARAMETERS
//  WIDTH_NBITS      `PU_WIDTH_NBITS  width of io_ack_data / core_rdata
//  TIMEOUT_CYCLES   1023             WAIT cycles before abandoning a request (>=4)
//  TO_NBITS         10               timeout counter width; must hold TIMEOUT_CYCLES
// PORTS
//  clk              in   1            clock
//  `RESET_SIG       in   1            synchronous, active-high reset
//  core_rd          in   1            core read request; held by core until core_rdy
//  core_cmd         in   io_type      {fid, addr}; addr[`PU_MEM_MULTI_DEPTH_RANGE] selects memory
//  core_rdy         out  1            initiator idle, core_rd accepted this cycle
//  core_rdata_valid out  1            one-cycle pulse, read complete
//  core_rdata       out  WIDTH_NBITS  read data; valid with core_rdata_valid, else 0
//  core_rd_err      out  1            with core_rdata_valid: request timed out, data 0
//  io_req           out  1            one-cycle request pulse to responder
//  io_cmd           out  io_type      command; stable from io_req until next accept
//  io_ack           in   1            responder acknowledge, one cycle
//  io_ack_data      in   WIDTH_NBITS  responder data, valid with io_ack
//  err_clr          in   1            clears sticky error flags
//  timeout_err      out  1            sticky: a timeout occurred
//  stray_ack_err    out  1            sticky: io_ack received outside WAIT
// BEHAVIOUR
//  - Reset: state IDLE; core_rdy=1 (combinational from IDLE), all other outputs 0,
//    io_cmd=0, timeout counter 0. Reset mid-operation abandons the request silently.
//  - FSM: IDLE -> REQ on core_rd&core_rdy (latch core_cmd into io_cmd);
//    REQ -> WAIT unconditionally (io_req=1 exactly during the REQ cycle, registered);
//    WAIT -> IDLE on io_ack, or on counter==TIMEOUT_CYCLES-1.
//  - core_rdy=1 only in IDLE; core_rd outside IDLE has no effect.
//  - WAIT: counter cleared on entry, +1 per cycle, saturates at TIMEOUT_CYCLES-1.
//  - io_ack in WAIT: next cycle core_rdata_valid=1, core_rdata=io_ack_data (registered),
//    core_rd_err=0. FSM in IDLE that same next cycle (back-to-back accept allowed).
//  - Timeout: next cycle core_rdata_valid=1, core_rdata=0, core_rd_err=1; timeout_err set.
//  - io_ack and timeout in same WAIT cycle: ack wins, no error.
//  - io_ack in IDLE or REQ (incl. late ack after timeout or reset): data discarded,
//    no core_rdata_valid, stray_ack_err set.
//  - io_ack_data ignored whenever io_ack=0.
//  - err_clr clears both sticky flags; a set event in the same cycle wins over clear.
//  - Min latency core_rd accept (cycle 0) -> io_req cycle 1 -> io_ack cycle N ->
//    core_rdata_valid cycle N+1. Throughput: one read per (N+1) cycles.
//  - io_req never asserted while a request is outstanding.
// TESTING
//  1 Reset then core_rd, fid=3 addr=0x12; responder acks 4 cycles after io_req with
//    0xDEADBEEF -> io_req one pulse at cycle 1, io_cmd={3,0x12}, valid at cycle 6, data ok.
//  2 core_rd held high continuously, acks at +3 -> one io_req per transaction, never two
//    outstanding, core_rdy only in IDLE, all data returned in order.
//  3 No ack, TIMEOUT_CYCLES=8 -> valid with core_rd_err=1, data 0, timeout_err=1;
//    ack arriving 2 cycles later -> stray_ack_err=1, no extra valid.
//  4 Ack on the exact final timeout cycle -> normal completion, core_rd_err=0, no flags.
//  5 Reset asserted in WAIT, ack 1 cycle after reset release -> outputs at reset values,
//    stray_ack_err=1; err_clr with simultaneous stray ack -> flag stays 1.
//  6 Random latency 1..20 against pu_switch_info_mem model, 1000 reads -> scoreboard
//    match, zero error flags.

Source files
------------

// File: rtl/pu_io_rd_initiator.sv
// Per-PU read initiator for the shared lookup-memory io_req/io_ack protocol.
// One request may be outstanding at a time. A watchdog abandons a silent responder, and sticky flags record errors.
module pu_io_rd_initiator #(
    parameter int WIDTH_NBITS    = 32,
    parameter int FID_NBITS      = 4,
    parameter int ADDR_NBITS     = 12,
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int TO_NBITS       = 10
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            core_rd,
    input  logic [FID_NBITS+ADDR_NBITS-1:0] core_cmd,
    output logic                            core_rdy,
    output logic                            core_rdata_valid,
    output logic [WIDTH_NBITS-1:0]          core_rdata,
    output logic                            core_rd_err,
    output logic                            io_req,
    output logic [FID_NBITS+ADDR_NBITS-1:0] io_cmd,
    input  logic                            io_ack,
    input  logic [WIDTH_NBITS-1:0]          io_ack_data,
    input  logic                            err_clr,
    output logic                            timeout_err,
    output logic                            stray_ack_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT
    } state_t;

    localparam logic [TO_NBITS-1:0] CNT_LAST = TO_NBITS'(TIMEOUT_CYCLES - 1);

    state_t              state;
    logic [TO_NBITS-1:0] wait_cnt;
    logic                ack_done;
    logic                timeout_hit;
    logic                stray_hit;

    assign core_rdy = (state == ST_IDLE);

    // An ack on the final watchdog cycle still completes the request normally.
    always_comb begin
        ack_done    = (state == ST_WAIT) && io_ack;
        timeout_hit = (state == ST_WAIT) && !io_ack && (wait_cnt == CNT_LAST);
        stray_hit   = (state != ST_WAIT) && io_ack;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= ST_IDLE;
            wait_cnt         <= '0;
            io_req           <= 1'b0;
            io_cmd           <= '0;
            core_rdata_valid <= 1'b0;
            core_rdata       <= '0;
            core_rd_err      <= 1'b0;
            timeout_err      <= 1'b0;
            stray_ack_err    <= 1'b0;
        end else begin
            io_req           <= 1'b0;
            core_rdata_valid <= 1'b0;
            core_rdata       <= '0;
            core_rd_err      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    wait_cnt <= '0;
                    if (core_rd) begin
                        io_cmd <= core_cmd;
                        io_req <= 1'b1;
                        state  <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    wait_cnt <= '0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (ack_done) begin
                        core_rdata_valid <= 1'b1;
                        core_rdata       <= io_ack_data;
                        state            <= ST_IDLE;
                    end else if (timeout_hit) begin
                        core_rdata_valid <= 1'b1;
                        core_rd_err      <= 1'b1;
                        state            <= ST_IDLE;
                    end else if (wait_cnt != CNT_LAST) begin
                        wait_cnt <= wait_cnt + TO_NBITS'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
            // If a new error arrives in the same cycle as err_clr, the flag stays set.
            timeout_err   <= timeout_hit | (timeout_err & ~err_clr);
            stray_ack_err <= stray_hit | (stray_ack_err & ~err_clr);
        end
    end

endmodule

// File: tb/tb_pu_io_rd_initiator.sv
// Bench for pu_io_rd_initiator. A transaction-age reference model is checked every cycle.
// Directed scenarios also carry hand-computed literal expectations.
module tb_pu_io_rd_initiator;

    localparam int W = 32;
    localparam int T = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_rd;
    logic [15:0] core_cmd;
    logic        core_rdy;
    logic        core_rdata_valid;
    logic [W-1:0] core_rdata;
    logic        core_rd_err;
    logic        io_req;
    logic [15:0] io_cmd;
    logic        io_ack;
    logic [W-1:0] io_ack_data;
    logic        err_clr;
    logic        timeout_err;
    logic        stray_ack_err;

    int cyc = 0;
    int mcyc = 0;
    int nChecks = 0;
    int nFails = 0;
    int nReq = 0;
    int nValid = 0;

    bit          respEn = 1'b0;
    bit          respRand = 1'b0;
    bit          respUseMem = 1'b0;
    int          respLat = 4;
    logic [31:0] respData = 32'h0;
    int          respLatNow;
    logic [11:0] respAddr;

    bit          modelOk = 1'b0;
    bit          mBusy = 1'b0;
    int          mIssue = 0;
    int          age;
    bit          setTo;
    bit          setStray;
    logic        eRdy, eReq, eValid, eErr, eTo, eStray;
    logic [15:0] eCmd;
    logic [31:0] eData;

    pu_io_rd_initiator #(
        .WIDTH_NBITS   (W),
        .FID_NBITS     (4),
        .ADDR_NBITS    (12),
        .TIMEOUT_CYCLES(T),
        .TO_NBITS      (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .core_rd         (core_rd),
        .core_cmd        (core_cmd),
        .core_rdy        (core_rdy),
        .core_rdata_valid(core_rdata_valid),
        .core_rdata      (core_rdata),
        .core_rd_err     (core_rd_err),
        .io_req          (io_req),
        .io_cmd          (io_cmd),
        .io_ack          (io_ack),
        .io_ack_data     (io_ack_data),
        .err_clr         (err_clr),
        .timeout_err     (timeout_err),
        .stray_ack_err   (stray_ack_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for the switch-info memory contents.
    function automatic logic [31:0] memData(input logic [11:0] addr);
        return 32'h5EED_0000 ^ ({20'h0, addr} * 32'h9E37_79B1);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic reportTimeout(input string name);
        nChecks++;
        nFails++;
        $display("[TB] FAIL %s: got no response, expected one within bound (cycle %0d)", name, cyc);
    endtask

    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic gotoCycle(input int n);
        while (cyc < n) waitCycle();
    endtask

    task automatic applyStimulus(input logic rd, input logic [15:0] cmd);
        core_rd  = rd;
        core_cmd = cmd;
    endtask

    task automatic waitReady();
        int g;
        g = 0;
        while (!core_rdy && g < 64) begin
            waitCycle();
            g++;
        end
        if (!core_rdy) reportTimeout("wait_core_rdy");
    endtask

    // Returns with the accept cycle in 'a'; the caller is then in cycle a+1.
    task automatic startRead(input logic [15:0] cmd, output int a);
        waitReady();
        applyStimulus(1'b1, cmd);
        a = cyc;
        waitCycle();
        applyStimulus(1'b0, cmd);
    endtask

    // Reference model driven by request age: it counts cycles since io_req, not FSM states.
    always @(posedge clk) begin
        if (reset) begin
            mBusy  = 1'b0;
            eReq   = 1'b0;
            eValid = 1'b0;
            eData  = '0;
            eErr   = 1'b0;
            eCmd   = '0;
            eTo    = 1'b0;
            eStray = 1'b0;
        end else begin
            setTo    = 1'b0;
            setStray = 1'b0;
            eReq     = 1'b0;
            eValid   = 1'b0;
            eData    = '0;
            eErr     = 1'b0;
            if (!mBusy) begin
                if (io_ack) setStray = 1'b1;
                if (core_rd) begin
                    mBusy  = 1'b1;
                    mIssue = mcyc + 1;
                    eReq   = 1'b1;
                    eCmd   = core_cmd;
                end
            end else begin
                age = mcyc - mIssue;
                if (age <= 0) begin
                    if (io_ack) setStray = 1'b1;
                end else if (io_ack) begin
                    eValid = 1'b1;
                    eData  = io_ack_data;
                    mBusy  = 1'b0;
                end else if (age >= T) begin
                    eValid = 1'b1;
                    eErr   = 1'b1;
                    setTo  = 1'b1;
                    mBusy  = 1'b0;
                end
            end
            eTo    = setTo | (eTo & !err_clr);
            eStray = setStray | (eStray & !err_clr);
        end
        eRdy    = !mBusy;
        mcyc    = mcyc + 1;
        modelOk = 1'b1;
    end

    always @(negedge clk) begin
        if (modelOk) begin
            checkOutput("core_rdy", core_rdy, eRdy);
            checkOutput("io_req", io_req, eReq);
            checkOutput("io_cmd", io_cmd, eCmd);
            checkOutput("core_rdata_valid", core_rdata_valid, eValid);
            checkOutput("core_rdata", core_rdata, eData);
            checkOutput("core_rd_err", core_rd_err, eErr);
            checkOutput("timeout_err", timeout_err, eTo);
            checkOutput("stray_ack_err", stray_ack_err, eStray);
            if (io_req) nReq++;
            if (core_rdata_valid) nValid++;
        end
    end

    // Responder: acks respLatNow cycles after the io_req cycle. Data is garbage while io_ack is low.
    initial begin
        io_ack      = 1'b0;
        io_ack_data = 32'hBAD0_0000;
        forever begin
            @(negedge clk);
            if (respEn && io_req) begin
                respLatNow = respRand ? $urandom_range(T, 1) : respLat;
                respAddr   = io_cmd[11:0];
                repeat (respLatNow) @(posedge clk);
                #1;
                io_ack      = 1'b1;
                io_ack_data = respUseMem ? memData(respAddr) : respData;
                @(posedge clk);
                #1;
                io_ack      = 1'b0;
                io_ack_data = 32'hBAD0_0000 ^ 32'(cyc);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no end of test, expected completion (cycle %0d)", cyc);
        nFails++;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int a;
        int r0;
        int v0;
        logic [3:0]  fid;
        logic [11:0] addr;

        reset   = 1'b1;
        core_rd = 1'b0;
        core_cmd = '0;
        err_clr = 1'b0;
        repeat (3) waitCycle();
        @(negedge clk);
        checkOutput("reset_core_rdy", core_rdy, 1);
        checkOutput("reset_valid", core_rdata_valid, 0);
        checkOutput("reset_io_req", io_req, 0);
        checkOutput("reset_io_cmd", io_cmd, 0);
        waitCycle();
        reset = 1'b0;

        $display("[TB] scenario 1: single read, ack 4 cycles after io_req");
        respEn = 1'b1; respRand = 1'b0; respUseMem = 1'b0; respLat = 4; respData = 32'hDEADBEEF;
        startRead(16'h3012, a);
        @(negedge clk);
        checkOutput("t1_io_req", io_req, 1);
        checkOutput("t1_io_cmd", io_cmd, 16'h3012);
        gotoCycle(a + 5);
        @(negedge clk);
        checkOutput("t1_valid_early", core_rdata_valid, 0);
        gotoCycle(a + 6);
        @(negedge clk);
        checkOutput("t1_valid", core_rdata_valid, 1);
        checkOutput("t1_data", core_rdata, 32'hDEADBEEF);
        checkOutput("t1_err", core_rd_err, 0);

        $display("[TB] scenario 2: core_rd held high, ack latency 3");
        respLat = 3; respUseMem = 1'b1;
        waitCycle();
        waitReady();
        applyStimulus(1'b1, 16'h10A0);
        a  = cyc;
        r0 = nReq;
        v0 = nValid;
        gotoCycle(a + 25);
        applyStimulus(1'b0, 16'h10A0);
        gotoCycle(a + 30);
        checkOutput("t2_io_req_count", 64'(nReq - r0), 5);
        checkOutput("t2_valid_count", 64'(nValid - v0), 5);

        $display("[TB] scenario 3: no ack, then a late ack");
        respEn = 1'b0;
        startRead(16'h2345, a);
        gotoCycle(a + 10);
        @(negedge clk);
        checkOutput("t3_valid", core_rdata_valid, 1);
        checkOutput("t3_err", core_rd_err, 1);
        checkOutput("t3_data", core_rdata, 0);
        checkOutput("t3_timeout_err", timeout_err, 1);
        gotoCycle(a + 12);
        io_ack = 1'b1; io_ack_data = 32'h1234_5678;
        waitCycle();
        io_ack = 1'b0;
        @(negedge clk);
        checkOutput("t3_stray", stray_ack_err, 1);
        checkOutput("t3_no_extra_valid", core_rdata_valid, 0);
        waitCycle();
        err_clr = 1'b1;
        waitCycle();
        err_clr = 1'b0;
        @(negedge clk);
        checkOutput("t3_clr_timeout", timeout_err, 0);
        checkOutput("t3_clr_stray", stray_ack_err, 0);

        $display("[TB] scenario 4: ack on final watchdog cycle");
        respEn = 1'b1; respUseMem = 1'b0; respLat = T; respData = 32'hCAFE_F00D;
        startRead(16'h4001, a);
        gotoCycle(a + 10);
        @(negedge clk);
        checkOutput("t4_valid", core_rdata_valid, 1);
        checkOutput("t4_err", core_rd_err, 0);
        checkOutput("t4_data", core_rdata, 32'hCAFE_F00D);
        checkOutput("t4_timeout_err", timeout_err, 0);
        checkOutput("t4_stray", stray_ack_err, 0);

        $display("[TB] scenario 5: reset during WAIT, ack after release");
        respEn = 1'b0;
        startRead(16'h5077, a);
        gotoCycle(a + 3);
        reset = 1'b1;
        gotoCycle(a + 5);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("t5_rdy", core_rdy, 1);
        checkOutput("t5_valid", core_rdata_valid, 0);
        checkOutput("t5_io_req", io_req, 0);
        checkOutput("t5_io_cmd", io_cmd, 0);
        checkOutput("t5_timeout_err", timeout_err, 0);
        waitCycle();
        io_ack = 1'b1; io_ack_data = 32'h0000_0BAD;
        waitCycle();
        io_ack = 1'b0;
        @(negedge clk);
        checkOutput("t5_stray", stray_ack_err, 1);
        checkOutput("t5_no_valid", core_rdata_valid, 0);
        waitCycle();
        err_clr = 1'b1; io_ack = 1'b1;
        waitCycle();
        err_clr = 1'b0; io_ack = 1'b0;
        @(negedge clk);
        checkOutput("t5_set_beats_clr", stray_ack_err, 1);
        waitCycle();
        err_clr = 1'b1;
        waitCycle();
        err_clr = 1'b0;
        @(negedge clk);
        checkOutput("t5_cleared", stray_ack_err, 0);

        $display("[TB] scenario 6: 1000 reads, random latency 1..%0d", T);
        respEn = 1'b1; respRand = 1'b1; respUseMem = 1'b1;
        v0 = nValid;
        for (int i = 0; i < 1000; i++) begin
            fid  = 4'($urandom_range(15, 0));
            addr = 12'($urandom_range(4095, 0));
            startRead({fid, addr}, a);
            repeat ($urandom_range(2, 0)) waitCycle();
        end
        gotoCycle(cyc + 15);
        @(negedge clk);
        checkOutput("t6_valid_count", 64'(nValid - v0), 1000);
        checkOutput("t6_timeout_err", timeout_err, 0);
        checkOutput("t6_stray", stray_ack_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
